// File: rtl/histogram_engine_if.sv
// Stream bundle for histogram_engine: packed-pixel input handshake and
// lane-summed bin readout handshake.
interface histogram_engine_if #(
   parameter int LANE_COUNT     = 4,
   parameter int BITS_PER_PIXEL = 8,
   parameter int BIN_COUNT      = 8,
   parameter int COUNT_WIDTH    = 16
);
   localparam int BIN_W = ($clog2(BIN_COUNT) > 0) ? $clog2(BIN_COUNT) : 1;

   logic                                 pix_valid;
   logic                                 pix_ready;
   logic [LANE_COUNT*BITS_PER_PIXEL-1:0] pix_data;
   logic                                 bin_valid;
   logic                                 bin_ready;
   logic [BIN_W-1:0]                     bin_index;
   logic [COUNT_WIDTH-1:0]               bin_count;

   modport master (
      output pix_valid, pix_data, bin_ready,
      input  pix_ready, bin_valid, bin_index, bin_count
   );

   modport slave (
      input  pix_valid, pix_data, bin_ready,
      output pix_ready, bin_valid, bin_index, bin_count
   );
endinterface

// File: rtl/histogram_engine.sv
// N-lane image histogram: per-lane counter banks fed by a two-stage bin/increment
// pipeline, followed by a saturating lane-summed readout stream.
module histogram_engine #(
   parameter int LANE_COUNT     = 4,
   parameter int BITS_PER_PIXEL = 8,
   parameter int BIN_COUNT      = 8,
   parameter int PIXEL_COUNT    = 16384,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   histogram_engine_if.slave  bus,
   output logic               busy,
   output logic               done,
   output logic               overflow
);
   localparam int BIN_W  = ($clog2(BIN_COUNT) > 0) ? $clog2(BIN_COUNT) : 1;
   localparam int SHIFT  = BITS_PER_PIXEL - $clog2(BIN_COUNT);
   localparam int BEATS  = PIXEL_COUNT / LANE_COUNT;
   localparam int BEAT_W = $clog2(BEATS + 1);
   localparam int SUM_W  = COUNT_WIDTH + $clog2(LANE_COUNT);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACCUM   = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_READOUT = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t                 state_r, state_next_s;
   logic [BEAT_W-1:0]      beat_r;
   logic                   stage1_valid_r;
   logic [BIN_W-1:0]       lane_bin_s [LANE_COUNT];
   logic [BIN_W-1:0]       lane_bin_r [LANE_COUNT];
   logic [COUNT_WIDTH-1:0] cnt_r      [LANE_COUNT][BIN_COUNT];
   logic [COUNT_WIDTH-1:0] cnt_next_s [LANE_COUNT][BIN_COUNT];
   logic                   sat_hit_s;
   logic [SUM_W-1:0]       sum_s;
   logic [COUNT_WIDTH-1:0] sum_sat_s;
   logic                   sum_over_s;
   logic [BIN_W-1:0]       bin_index_r, load_idx_s;
   logic [COUNT_WIDTH-1:0] bin_count_r;
   logic                   overflow_r;
   logic                   accept_s, last_beat_s, handshake_s, last_bin_s, load_s;

   assign accept_s    = bus.pix_valid && (state_r == ST_ACCUM);
   assign last_beat_s = accept_s && (beat_r == BEAT_W'(BEATS - 1));
   assign handshake_s = bus.bin_ready && (state_r == ST_READOUT);
   assign last_bin_s  = (bin_index_r == BIN_W'(BIN_COUNT - 1));
   assign load_s      = (state_r == ST_DRAIN) || (handshake_s && !last_bin_s);
   assign load_idx_s  = (state_r == ST_DRAIN) ? {BIN_W{1'b0}} : bin_index_r + BIN_W'(1'b1);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE:    if (start) state_next_s = ST_CLEAR; else state_next_s = ST_IDLE;
         ST_CLEAR:   state_next_s = ST_ACCUM;
         ST_ACCUM:   if (last_beat_s) state_next_s = ST_DRAIN; else state_next_s = ST_ACCUM;
         ST_DRAIN:   state_next_s = ST_READOUT;
         ST_READOUT: if (handshake_s && last_bin_s) state_next_s = ST_DONE;
                     else state_next_s = ST_READOUT;
         ST_DONE:    state_next_s = ST_IDLE;
         default:    state_next_s = ST_IDLE;
      endcase
   end

   // Status and handshake outputs decoded from the state register
   always_comb begin
      bus.pix_ready = 1'b0;
      bus.bin_valid = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state_r)
         ST_IDLE:    busy = 1'b0;
         ST_ACCUM:   bus.pix_ready = 1'b1;
         ST_READOUT: bus.bin_valid = 1'b1;
         ST_DONE:    done = 1'b1;
         default:    busy = 1'b1;
      endcase
   end

   // Stage 1: bin number is the top bits of each lane's pixel
   always_comb begin
      for (int l = 0; l < LANE_COUNT; l++) begin
         lane_bin_s[l] = BIN_W'(bus.pix_data[l*BITS_PER_PIXEL +: BITS_PER_PIXEL] >> SHIFT);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         beat_r         <= {BEAT_W{1'b0}};
         stage1_valid_r <= 1'b0;
         for (int l = 0; l < LANE_COUNT; l++) lane_bin_r[l] <= {BIN_W{1'b0}};
      end else begin
         stage1_valid_r <= accept_s;
         if (state_r == ST_CLEAR) begin
            beat_r <= {BEAT_W{1'b0}};
         end else if (accept_s) begin
            beat_r <= beat_r + BEAT_W'(1'b1);
         end else begin
            beat_r <= beat_r;
         end
         if (accept_s) lane_bin_r <= lane_bin_s;
         else          lane_bin_r <= lane_bin_r;
      end
   end

   // Stage 2: saturating increment of each lane's own bank
   always_comb begin
      cnt_next_s = cnt_r;
      sat_hit_s  = 1'b0;
      if (state_r == ST_CLEAR) begin
         for (int l = 0; l < LANE_COUNT; l++)
            for (int b = 0; b < BIN_COUNT; b++)
               cnt_next_s[l][b] = {COUNT_WIDTH{1'b0}};
      end else if (stage1_valid_r) begin
         for (int l = 0; l < LANE_COUNT; l++) begin
            if (cnt_r[l][lane_bin_r[l]] == CNT_MAX) sat_hit_s = 1'b1;
            else cnt_next_s[l][lane_bin_r[l]] = cnt_r[l][lane_bin_r[l]] + COUNT_WIDTH'(1'b1);
         end
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int l = 0; l < LANE_COUNT; l++)
            for (int b = 0; b < BIN_COUNT; b++)
               cnt_r[l][b] <= {COUNT_WIDTH{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   // Sum uses next-cycle counter values so the final increment landing in DRAIN is seen
   always_comb begin
      sum_s = {SUM_W{1'b0}};
      for (int l = 0; l < LANE_COUNT; l++) begin
         sum_s = sum_s + SUM_W'(cnt_next_s[l][load_idx_s]);
      end
      if (sum_s > SUM_W'(CNT_MAX)) begin
         sum_over_s = 1'b1;
         sum_sat_s  = CNT_MAX;
      end else begin
         sum_over_s = 1'b0;
         sum_sat_s  = sum_s[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bin_index_r <= {BIN_W{1'b0}};
         bin_count_r <= {COUNT_WIDTH{1'b0}};
      end else if (load_s) begin
         bin_index_r <= load_idx_s;
         bin_count_r <= sum_sat_s;
      end else begin
         bin_index_r <= bin_index_r;
         bin_count_r <= bin_count_r;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (state_r == ST_CLEAR) begin
         overflow_r <= 1'b0;
      end else if (sat_hit_s || (load_s && sum_over_s)) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign bus.bin_index = bin_index_r;
   assign bus.bin_count = bin_count_r;
   assign overflow      = overflow_r;
endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: a 4-lane/16-bit instance and a 2-lane/3-bit
// instance driven with directed and random frames, checked against a histogram model.
module tb_histogram_engine;
   localparam int BPP     = 8;
   localparam int BINS    = 8;
   localparam int BIN_DIV = 256 / BINS;
   localparam int A_LANES = 4;
   localparam int A_BEATS = 4;
   localparam int A_MAX   = 65535;
   localparam int B_LANES = 2;
   localparam int B_BEATS = 10;
   localparam int B_MAX   = 7;

   logic clock, reset, start_a, start_b;
   logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

   histogram_engine_if #(.LANE_COUNT(4), .BITS_PER_PIXEL(8), .BIN_COUNT(8), .COUNT_WIDTH(16)) a_if ();
   histogram_engine_if #(.LANE_COUNT(2), .BITS_PER_PIXEL(8), .BIN_COUNT(8), .COUNT_WIDTH(3))  b_if ();

   histogram_engine #(.LANE_COUNT(4), .BITS_PER_PIXEL(8), .BIN_COUNT(8),
                      .PIXEL_COUNT(16), .COUNT_WIDTH(16)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .bus(a_if.slave),
      .busy(busy_a), .done(done_a), .overflow(ovf_a));

   histogram_engine #(.LANE_COUNT(2), .BITS_PER_PIXEL(8), .BIN_COUNT(8),
                      .PIXEL_COUNT(20), .COUNT_WIDTH(3)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .bus(b_if.slave),
      .busy(busy_b), .done(done_b), .overflow(ovf_b));

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int px_q[$];
   int exp_cnt[BINS];
   int exp_ov;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Pixel stream in arrival order; lane of pixel i is i % lanes.
   task automatic fill(input int n, input int mode);
      int pat[4] = '{0, 32, 160, 224};
      px_q.delete();
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       px_q.push_back(0);
            1:       px_q.push_back(pat[i % 4]);
            2:       px_q.push_back(int'($urandom_range(0, 255)));
            3:       px_q.push_back(int'($urandom_range(0, 63)));
            default: px_q.push_back(0);
         endcase
      end
   endtask

   task automatic model(input int lanes, input int cmax);
      int h[4][BINS];
      int s, c;
      for (int l = 0; l < 4; l++) for (int b = 0; b < BINS; b++) h[l][b] = 0;
      foreach (px_q[i]) h[i % lanes][px_q[i] / BIN_DIV]++;
      exp_ov = 0;
      for (int b = 0; b < BINS; b++) begin
         s = 0;
         for (int l = 0; l < lanes; l++) begin
            c = h[l][b];
            if (c > cmax) begin c = cmax; exp_ov = 1; end
            s += c;
         end
         if (s > cmax) begin s = cmax; exp_ov = 1; end
         exp_cnt[b] = s;
      end
   endtask

   task automatic start_pulse(input bit sel);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clock); @(negedge clock);
      start_a = 1'b0; start_b = 1'b0;
      check(sel ? "b_busy_clear" : "a_busy_clear", sel ? busy_b : busy_a, 1);
   endtask

   task automatic feed(input bit sel, input int nbeats, input int gap_mode, input bit stray);
      int lanes, beat, guard, d;
      logic v, tog, acc;
      logic [31:0] w;
      lanes = sel ? B_LANES : A_LANES;
      beat = 0; guard = 0; tog = 1'b1;
      while (beat < nbeats && guard < 200) begin
         guard++;
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = tog;
            default: v = 1'($urandom_range(0, 1));
         endcase
         tog = ~tog;
         w = 32'd0;
         for (int l = 0; l < lanes; l++) begin
            d = px_q[beat*lanes + l];
            w[l*BPP +: BPP] = d[BPP-1:0];
         end
         if (!v) w = $urandom();
         if (guard == 2) check(sel ? "b_ovf_cleared" : "a_ovf_cleared", sel ? ovf_b : ovf_a, 0);
         if (sel) begin
            b_if.pix_valid = v; b_if.pix_data = w[15:0];
            start_b = stray && (guard == 3);
            acc = b_if.pix_valid && b_if.pix_ready;
         end else begin
            a_if.pix_valid = v; a_if.pix_data = w;
            start_a = stray && (guard == 3);
            acc = a_if.pix_valid && a_if.pix_ready;
         end
         @(posedge clock); @(negedge clock);
         if (acc) beat++;
      end
      a_if.pix_valid = 1'b0; b_if.pix_valid = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      check(sel ? "b_beats" : "a_beats", beat, nbeats);
   endtask

   task automatic readout(input bit sel, input int stall_bin, input int stall_len, input bit stray);
      int idx, guard, left;
      logic hs, bv, rdy;
      string p;
      p = sel ? "b" : "a";
      idx = 0; guard = 0; left = stall_len;
      while (idx < BINS && guard < 200) begin
         guard++;
         hs = 1'b0;
         bv = sel ? b_if.bin_valid : a_if.bin_valid;
         if (bv) begin
            if (idx == stall_bin && left > 0) begin rdy = 1'b0; left--; end
            else begin rdy = 1'b1; end
            check($sformatf("%s_idx%0d", p, idx), sel ? 32'(b_if.bin_index) : 32'(a_if.bin_index), idx);
            check($sformatf("%s_cnt%0d", p, idx), sel ? 32'(b_if.bin_count) : 32'(a_if.bin_count), exp_cnt[idx]);
            hs = rdy;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         if (sel) begin b_if.bin_ready = rdy; start_b = stray && (idx == 3); end
         else     begin a_if.bin_ready = rdy; start_a = stray && (idx == 3); end
         @(posedge clock); @(negedge clock);
         if (hs) idx++;
      end
      a_if.bin_ready = 1'b0; b_if.bin_ready = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      check({p, "_nbins"}, idx, BINS);
      check({p, "_done"}, sel ? done_b : done_a, 1);
      check({p, "_done_bv"}, sel ? b_if.bin_valid : a_if.bin_valid, 0);
      check({p, "_done_busy"}, sel ? busy_b : busy_a, 1);
      check({p, "_ovf"}, sel ? ovf_b : ovf_a, exp_ov);
      @(posedge clock); @(negedge clock);
      check({p, "_done_pulse"}, sel ? done_b : done_a, 0);
      check({p, "_idle"}, sel ? busy_b : busy_a, 0);
      check({p, "_ovf_hold"}, sel ? ovf_b : ovf_a, exp_ov);
   endtask

   task automatic run_frame(input bit sel, input int gap_mode, input int stall_bin,
                            input int stall_len, input bit stray);
      start_pulse(sel);
      feed(sel, sel ? B_BEATS : A_BEATS, gap_mode, stray);
      check(sel ? "b_ready_drop" : "a_ready_drop", sel ? b_if.pix_ready : a_if.pix_ready, 0);
      readout(sel, stall_bin, stall_len, stray);
   endtask

   task automatic check_reset_state();
      check("rst_a_busy", busy_a, 0);      check("rst_b_busy", busy_b, 0);
      check("rst_a_ready", a_if.pix_ready, 0); check("rst_a_bv", a_if.bin_valid, 0);
      check("rst_a_idx", a_if.bin_index, 0);   check("rst_a_cnt", a_if.bin_count, 0);
      check("rst_a_done", done_a, 0);      check("rst_a_ovf", ovf_a, 0);
      check("rst_b_ready", b_if.pix_ready, 0); check("rst_b_cnt", b_if.bin_count, 0);
      check("rst_b_ovf", ovf_b, 0);
   endtask

   initial begin
      int ndone;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      a_if.pix_valid = 1'b0; a_if.pix_data = 32'd0; a_if.bin_ready = 1'b0;
      b_if.pix_valid = 1'b0; b_if.pix_data = 16'd0; b_if.bin_ready = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_state();
      reset = 1'b0;
      @(negedge clock);

      // Directed 4-lane frames: all-zero, fixed lane pattern
      fill(16, 0); model(A_LANES, A_MAX); run_frame(1'b0, 0, -1, 0, 1'b0);
      fill(16, 1); model(A_LANES, A_MAX); run_frame(1'b0, 0, -1, 0, 1'b0);
      // Alternating pix_valid, three-cycle stall on bin 2
      fill(16, 1); model(A_LANES, A_MAX); run_frame(1'b0, 1, 2, 3, 1'b0);
      fill(16, 2); model(A_LANES, A_MAX); run_frame(1'b0, 1, 2, 3, 1'b0);
      // Random frames with random gaps/stalls and stray start pulses
      for (int k = 0; k < 4; k++) begin
         fill(16, 2); model(A_LANES, A_MAX);
         run_frame(1'b0, 2, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 1'b1);
      end

      // Reset part-way through accumulation abandons the frame
      fill(16, 2);
      start_pulse(1'b0);
      feed(1'b0, 2, 0, 1'b0);
      reset = 1'b1;
      @(posedge clock); @(negedge clock);
      check_reset_state();
      reset = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(posedge clock); @(negedge clock);
         if (done_a === 1'b1) ndone++;
      end
      check("a_abort_no_done", ndone, 0);
      check("a_abort_idle", busy_a, 0);
      fill(16, 2); model(A_LANES, A_MAX); run_frame(1'b0, 0, -1, 0, 1'b0);

      // Narrow-counter instance: saturation of lanes and of the sum
      fill(20, 0); model(B_LANES, B_MAX); run_frame(1'b1, 0, -1, 0, 1'b0);
      fill(20, 2); model(B_LANES, B_MAX); run_frame(1'b1, 2, -1, 0, 1'b0);
      fill(20, 3); model(B_LANES, B_MAX); run_frame(1'b1, 1, 5, 2, 1'b1);
      fill(20, 3); model(B_LANES, B_MAX); run_frame(1'b1, 2, int'($urandom_range(0, 7)), 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/histogram_engine.md
Name: histogram_engine

Overview:
Parametrised N-lane image histogram engine, successor to the fixed 4-lane, 8-bin histogram top. Accepts packed multi-pixel words over a valid/ready stream, bins every pixel into per-lane counter banks, then streams the lane-summed bin counts out over a valid/ready readout port. Sits between the image RAM reader and the UART transmit distributer, and exposes busy/done/overflow status.

Parameters:
LANE_COUNT, 4, pixels per input word, one counter bank per lane (≥1).
BITS_PER_PIXEL, 8, pixel width.
BIN_COUNT, 8, number of bins, power of 2, ≤ 2**BITS_PER_PIXEL.
PIXEL_COUNT, 16384, pixels per frame, multiple of LANE_COUNT.
COUNT_WIDTH, 16, width of per-lane counters and of summed output.

Ports:
clock  in  1  single clock domain.
reset  in  1  synchronous, active-high.
start  in  1  pulse; begins a frame when IDLE, ignored otherwise.
pix_valid  in  1  input word valid.
pix_ready  out  1  engine accepts a word this cycle.
pix_data  in  LANE_COUNT*BITS_PER_PIXEL  lane k = bits [k*BPP +: BPP].
bin_valid  out  1  readout word valid.
bin_ready  in  1  downstream accepts readout word.
bin_index  out  $clog2(BIN_COUNT)  bin being presented.
bin_count  out  COUNT_WIDTH  lane-summed count for bin_index.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last bin is accepted.
overflow  out  1  sticky per frame; any saturation occurred.

Behaviour:
- Reset: state IDLE; all counters 0; pix_ready=0, bin_valid=0, bin_index=0, bin_count=0, busy=0, done=0, overflow=0. Reset mid-frame abandons the frame; no done pulse.
- Bin select: bin = pixel >> (BITS_PER_PIXEL - $clog2(BIN_COUNT)), i.e. top bits of the pixel.
- States: IDLE -> CLEAR -> ACCUM -> DRAIN -> READOUT -> DONE -> IDLE.
- IDLE: waits for start. start=1 -> CLEAR.
- CLEAR: one cycle; zeroes all LANE_COUNT*BIN_COUNT counters, clears overflow and beat counter. -> ACCUM.
- ACCUM: pix_ready=1. A beat is accepted when pix_valid&&pix_ready. Accepted lane bins are registered (stage 1); matching counters increment on the next clock (stage 2). Lanes own separate banks, so same-bin hits across lanes in one beat are not hazards. Beat counter counts to PIXEL_COUNT/LANE_COUNT. On the cycle the last beat is accepted -> DRAIN, and pix_ready drops the next cycle. Gaps in pix_valid are allowed and have no effect.
- DRAIN: one cycle so the final stage-2 increment lands. -> READOUT with bin_index=0.
- Arithmetic: a per-lane counter at 2**COUNT_WIDTH-1 holds its value and sets overflow. The readout sum is formed at COUNT_WIDTH+$clog2(LANE_COUNT) bits, then saturated to COUNT_WIDTH; saturation also sets overflow.
- READOUT: bin_valid=1. bin_index and bin_count are registered and must stay stable while bin_ready=0. On handshake: if bin_index==BIN_COUNT-1 -> DONE, otherwise increment bin_index and present the new count on the next cycle. Back-to-back handshakes give one bin per clock.
- DONE: done=1 for one cycle, bin_valid=0. -> IDLE. Counters keep their values until the next CLEAR. overflow holds until the next CLEAR or reset.
- start asserted outside IDLE is ignored. start and reset together: reset wins.

Test Plan:
- LANE_COUNT=4, PIXEL_COUNT=16, BIN_COUNT=8, all pixels 0x00, bin_ready=1 -> bins 0..7 read as 16,0,0,0,0,0,0,0. done pulses one cycle after bin 7 handshake. overflow=0.
- Same config, pix_data=0xE0A02000 for 4 beats (lanes 0x00,0x20,0xA0,0xE0) -> bins 0,1,5,7 each count 4, all others 0.
- pix_valid toggled 1/0 every cycle during ACCUM, and bin_ready held low 3 cycles on bin 2 -> counts identical to the unstalled run. bin_index/bin_count stable while stalled. Exactly 8 bin handshakes.
- COUNT_WIDTH=3, LANE_COUNT=2, PIXEL_COUNT=20, all pixels 0 -> each lane saturates at 7, sum 14 saturates to 7. overflow=1 through DONE, cleared by the next start's CLEAR.
- reset pulsed mid-ACCUM after 2 beats, then a new start with a full frame -> no done from the first frame. Second frame counts contain no residue from the aborted frame.
- start pulsed during ACCUM and READOUT -> ignored. Frame completes normally and busy deasserts after DONE.
